// File: rtl/stage_w_if.sv
// Bus between the memory-access stage and the writeback stage.
// The M-side pipeline fields, the data-memory read data and the pipeline
// controls flow into W; the register-file write port, the forwarding flag
// and the two counters flow out of it.
interface stage_w_if #(
    parameter int CNT_W = 32
);
    logic             m_valid;
    logic             m_reg_we;
    logic [4:0]       m_rd;
    logic [5:0]       m_alucode;
    logic             m_is_load;
    logic [31:0]      m_alu_result;
    logic [4:0]       m_byte_offset;
    logic             m_is_hardware;
    logic [31:0]      dm_r_data;
    logic             stall;
    logic             flush;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             fwd_valid;
    logic [CNT_W-1:0] hw_counter;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output m_valid, m_reg_we, m_rd, m_alucode, m_is_load, m_alu_result,
               m_byte_offset, m_is_hardware, dm_r_data, stall, flush,
        input  rf_we, rf_waddr, rf_wdata, fwd_valid, hw_counter, retire_count
    );

    modport slave (
        input  m_valid, m_reg_we, m_rd, m_alucode, m_is_load, m_alu_result,
               m_byte_offset, m_is_hardware, dm_r_data, stall, flush,
        output rf_we, rf_waddr, rf_wdata, fwd_valid, hw_counter, retire_count
    );
endinterface

// File: rtl/stage_w.sv
// Writeback stage: M/W pipeline register, load alignment and extension,
// cycle-counter loads, register-file write port, forwarding flag, and the
// retired-instruction counter. Sync RAM data is captured into a hold
// register while W is stalled so a stalled load writes back its own data.
module stage_w #(
    parameter int CNT_W = 32
) (
    input  logic     clk,
    input  logic     reset,
    stage_w_if.slave bus
);
    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;

    logic             w_valid_q,   w_valid_d;
    logic             w_reg_we_q,  w_reg_we_d;
    logic [4:0]       w_rd_q,      w_rd_d;
    logic [5:0]       w_alucode_q, w_alucode_d;
    logic             w_is_load_q, w_is_load_d;
    logic [31:0]      w_result_q,  w_result_d;
    logic [4:0]       w_offset_q,  w_offset_d;
    logic             w_is_hw_q,   w_is_hw_d;
    logic             hold_valid_q, hold_valid_d;
    logic [31:0]      hold_data_q,  hold_data_d;
    logic [CNT_W-1:0] hw_cnt_q,     hw_cnt_d;
    logic [CNT_W-1:0] retire_q,     retire_d;

    logic [31:0]      hw32;
    logic [31:0]      raw;
    logic [15:0]      sh;
    logic [31:0]      ext;

    // Counter value as seen on the 32-bit load data path.
    if (CNT_W >= 32) begin : g_hw_trunc
        assign hw32 = hw_cnt_q[31:0];
    end else begin : g_hw_zext
        assign hw32 = {{(32-CNT_W){1'b0}}, hw_cnt_q};
    end

    // Next state of the M/W register: hold on stall, bubble on flush, else capture.
    always_comb begin
        w_valid_d   = w_valid_q;
        w_reg_we_d  = w_reg_we_q;
        w_rd_d      = w_rd_q;
        w_alucode_d = w_alucode_q;
        w_is_load_d = w_is_load_q;
        w_result_d  = w_result_q;
        w_offset_d  = w_offset_q;
        w_is_hw_d   = w_is_hw_q;
        if (!bus.stall) begin
            if (bus.flush) begin
                w_valid_d   = 1'b0;
                w_reg_we_d  = 1'b0;
                w_rd_d      = '0;
                w_alucode_d = '0;
                w_is_load_d = 1'b0;
                w_result_d  = '0;
                w_offset_d  = '0;
                w_is_hw_d   = 1'b0;
            end else begin
                w_valid_d   = bus.m_valid;
                w_reg_we_d  = bus.m_reg_we;
                w_rd_d      = bus.m_rd;
                w_alucode_d = bus.m_alucode;
                w_is_load_d = bus.m_is_load;
                w_result_d  = bus.m_alu_result;
                w_offset_d  = bus.m_byte_offset;
                w_is_hw_d   = bus.m_is_hardware;
            end
        end
    end

    // Hold register: grab RAM data on the first stalled cycle of a load, release when W advances.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (bus.stall) begin
            if (w_valid_q && w_is_load_q && !hold_valid_q) begin
                hold_data_d  = bus.dm_r_data;
                hold_valid_d = 1'b1;
            end
        end else begin
            hold_valid_d = 1'b0;
        end
    end

    // Free-running cycle counter and retire counter (counts any valid instruction leaving W).
    always_comb begin
        hw_cnt_d = hw_cnt_q + CNT_W'(1);
        retire_d = retire_q + CNT_W'(w_valid_q & ~bus.stall);
    end

    // Load data selection, alignment and extension.
    always_comb begin
        raw = w_is_hw_q ? hw32 : (hold_valid_q ? hold_data_q : bus.dm_r_data);
        sh  = 16'(raw >> w_offset_q);
        case (w_alucode_q)
            ALU_LB:  ext = {{24{sh[7]}}, sh[7:0]};
            ALU_LBU: ext = {24'h0, sh[7:0]};
            ALU_LH:  ext = {{16{sh[15]}}, sh};
            ALU_LHU: ext = {16'h0, sh};
            ALU_LW:  ext = raw;
            default: ext = raw;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid_q    <= 1'b0;
            w_reg_we_q   <= 1'b0;
            w_rd_q       <= '0;
            w_alucode_q  <= '0;
            w_is_load_q  <= 1'b0;
            w_result_q   <= '0;
            w_offset_q   <= '0;
            w_is_hw_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hw_cnt_q     <= '0;
            retire_q     <= '0;
        end else begin
            w_valid_q    <= w_valid_d;
            w_reg_we_q   <= w_reg_we_d;
            w_rd_q       <= w_rd_d;
            w_alucode_q  <= w_alucode_d;
            w_is_load_q  <= w_is_load_d;
            w_result_q   <= w_result_d;
            w_offset_q   <= w_offset_d;
            w_is_hw_q    <= w_is_hw_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hw_cnt_q     <= hw_cnt_d;
            retire_q     <= retire_d;
        end
    end

    // Register-file write port and forwarding outputs.
    always_comb begin
        bus.rf_we        = w_valid_q & w_reg_we_q & (w_rd_q != '0) & ~bus.stall;
        bus.rf_waddr     = w_rd_q;
        bus.rf_wdata     = w_is_load_q ? ext : w_result_q;
        bus.fwd_valid    = bus.rf_we;
        bus.hw_counter   = hw_cnt_q;
        bus.retire_count = retire_q;
    end
endmodule

// File: tb/tb_stage_w.sv
// Directed bench for stage_w: a table of single-instruction vectors plus
// hand-written sequences for counter loads, stall/hold, flush, reset
// mid-stall, and counter wrap (on a narrow-counter second instance).
module tb_stage_w;
    localparam logic [5:0] ALU_ADD = 6'd1;
    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_ODD = 6'd40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stage_w_if #(.CNT_W(32)) bus ();
    stage_w    #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    stage_w_if #(.CNT_W(4)) bus4 ();
    stage_w    #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        logic        valid;
        logic        reg_we;
        logic [4:0]  rd;
        logic [5:0]  alu;
        logic        is_load;
        logic [31:0] res;
        logic [4:0]  off;
        logic [31:0] dm;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned edges = 0;
    int unsigned exp_retire = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        #1;
    endtask

    task automatic idle_m();
        bus.m_valid       = 1'b0;
        bus.m_reg_we      = 1'b0;
        bus.m_rd          = '0;
        bus.m_alucode     = '0;
        bus.m_is_load     = 1'b0;
        bus.m_alu_result  = '0;
        bus.m_byte_offset = '0;
        bus.m_is_hardware = 1'b0;
    endtask

    task automatic drive_m(input logic valid, input logic reg_we, input logic [4:0] rd,
                           input logic [5:0] alu, input logic is_load, input logic [31:0] res,
                           input logic [4:0] off, input logic is_hw);
        bus.m_valid       = valid;
        bus.m_reg_we      = reg_we;
        bus.m_rd          = rd;
        bus.m_alucode     = alu;
        bus.m_is_load     = is_load;
        bus.m_alu_result  = res;
        bus.m_byte_offset = off;
        bus.m_is_hardware = is_hw;
    endtask

    function automatic vec_t mk(input logic valid, input logic reg_we, input logic [4:0] rd,
                                input logic [5:0] alu, input logic is_load, input logic [31:0] res,
                                input logic [4:0] off, input logic [31:0] dm,
                                input logic exp_we, input logic [31:0] exp_wdata);
        vec_t v;
        v.valid = valid; v.reg_we = reg_we; v.rd = rd; v.alu = alu; v.is_load = is_load;
        v.res = res; v.off = off; v.dm = dm; v.exp_we = exp_we; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    initial begin
        //           valid we rd  alu      ld  result        off  dm            we  wdata
        vecs[0]  = mk(1, 1, 5,  ALU_ADD, 0, 32'h12345678, 0,  32'h0,        1, 32'h12345678);
        vecs[1]  = mk(1, 1, 0,  ALU_ADD, 0, 32'h12345678, 0,  32'h0,        0, 32'h12345678);
        vecs[2]  = mk(1, 1, 6,  ALU_LB,  1, 32'h100,      8,  32'h0080FF00, 1, 32'hFFFFFFFF);
        vecs[3]  = mk(1, 1, 6,  ALU_LBU, 1, 32'h100,      8,  32'h0080FF00, 1, 32'h000000FF);
        vecs[4]  = mk(1, 1, 6,  ALU_LH,  1, 32'h100,      16, 32'h0080FF00, 1, 32'h00000080);
        vecs[5]  = mk(1, 1, 6,  ALU_LW,  1, 32'h100,      0,  32'h0080FF00, 1, 32'h0080FF00);
        vecs[6]  = mk(1, 1, 10, ALU_LH,  1, 32'h103,      24, 32'h80000000, 1, 32'h00000080);
        vecs[7]  = mk(1, 1, 11, ALU_LHU, 1, 32'h200,      0,  32'h12348001, 1, 32'h00008001);
        vecs[8]  = mk(1, 1, 12, ALU_LH,  1, 32'h200,      0,  32'h12348001, 1, 32'hFFFF8001);
        vecs[9]  = mk(1, 1, 13, ALU_LB,  1, 32'h203,      24, 32'h7F000000, 1, 32'h0000007F);
        vecs[10] = mk(1, 1, 14, ALU_ODD, 1, 32'h204,      8,  32'hA5A5_5A5A, 1, 32'hA5A55A5A);
        vecs[11] = mk(0, 1, 3,  ALU_ADD, 0, 32'h00000777, 0,  32'h0,        0, 32'h00000777);

        bus4.m_valid = 1'b0; bus4.m_reg_we = 1'b0; bus4.m_rd = '0; bus4.m_alucode = '0;
        bus4.m_is_load = 1'b0; bus4.m_alu_result = '0; bus4.m_byte_offset = '0;
        bus4.m_is_hardware = 1'b0; bus4.dm_r_data = '0; bus4.stall = 1'b0; bus4.flush = 1'b0;

        idle_m();
        bus.dm_r_data = '0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        reset         = 1'b1;
        #12;
        chk("reset_rf_we",    32'(bus.rf_we), 32'd0);
        chk("reset_waddr",    32'(bus.rf_waddr), 32'd0);
        chk("reset_wdata",    bus.rf_wdata, 32'd0);
        chk("reset_hw",       bus.hw_counter, 32'd0);
        chk("reset_retire",   bus.retire_count, 32'd0);

        @(posedge clk);
        #1 reset = 1'b0;
        edges = 0;
        repeat (5) step();
        chk("idle_rf_we",  32'(bus.rf_we), 32'd0);
        chk("idle_hw5",    bus.hw_counter, 32'd5);
        chk("idle_retire", bus.retire_count, 32'd0);

        for (int i = 0; i < NV; i++) begin
            drive_m(vecs[i].valid, vecs[i].reg_we, vecs[i].rd, vecs[i].alu, vecs[i].is_load,
                    vecs[i].res, vecs[i].off, 1'b0);
            step();
            idle_m();
            bus.dm_r_data = vecs[i].dm;
            #1;
            chk($sformatf("vec%0d_we", i),    32'(bus.rf_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_fwd", i),   32'(bus.fwd_valid), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_waddr", i), 32'(bus.rf_waddr), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_wdata", i), bus.rf_wdata, vecs[i].exp_wdata);
            if (vecs[i].valid) exp_retire++;
        end
        step();
        chk("table_retire", bus.retire_count, exp_retire);
        chk("table_hw",     bus.hw_counter, edges);

        // Load from the cycle counter: W cycle sees counter == 100.
        while (edges < 99) step();
        drive_m(1, 1, 2, ALU_LW, 1, 32'hFFFF0000, 0, 1'b1);
        step();
        idle_m();
        bus.dm_r_data = 32'hDEADBEEF;
        #1;
        chk("hwload_counter", bus.hw_counter, 32'd100);
        chk("hwload_we",      32'(bus.rf_we), 32'd1);
        chk("hwload_wdata",   bus.rf_wdata, 32'd100);
        exp_retire++;
        step();

        // Stalled load keeps the data read in its first W cycle; flush during stall is ignored.
        drive_m(1, 1, 7, ALU_LW, 1, 32'h300, 0, 1'b0);
        step();
        drive_m(1, 1, 8, ALU_ADD, 0, 32'h00000055, 0, 1'b0);
        bus.dm_r_data = 32'hCAFEBABE;
        bus.stall = 1'b1;
        #1;
        chk("stall_c1_we", 32'(bus.rf_we), 32'd0);
        step();
        bus.dm_r_data = 32'h0;
        bus.flush = 1'b1;
        #1;
        chk("stall_c2_we",    32'(bus.rf_we), 32'd0);
        chk("stall_c2_wdata", bus.rf_wdata, 32'hCAFEBABE);
        step();
        bus.flush = 1'b0;
        #1;
        chk("stall_c3_we",     32'(bus.rf_we), 32'd0);
        chk("stall_c3_retire", bus.retire_count, exp_retire);
        step();
        bus.stall = 1'b0;
        #1;
        chk("stall_end_we",    32'(bus.rf_we), 32'd1);
        chk("stall_end_waddr", 32'(bus.rf_waddr), 32'd7);
        chk("stall_end_wdata", bus.rf_wdata, 32'hCAFEBABE);
        chk("stall_end_retire", bus.retire_count, exp_retire);
        step();
        exp_retire++;
        idle_m();
        #1;
        chk("after_stall_we",     32'(bus.rf_we), 32'd1);
        chk("after_stall_waddr",  32'(bus.rf_waddr), 32'd8);
        chk("after_stall_wdata",  bus.rf_wdata, 32'h00000055);
        chk("after_stall_retire", bus.retire_count, exp_retire);
        step();
        exp_retire++;

        // Flush replaces a valid M instruction with a bubble.
        drive_m(1, 1, 9, ALU_ADD, 0, 32'h00000999, 0, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle_m();
        #1;
        chk("flush_we",    32'(bus.rf_we), 32'd0);
        chk("flush_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("flush_wdata", bus.rf_wdata, 32'd0);
        step();
        chk("flush_retire", bus.retire_count, exp_retire);

        // Narrow counter wraps from all-ones to zero.
        while ((edges % 16) != 15) step();
        chk("wrap_at_max", 32'(bus4.hw_counter), 32'd15);
        step();
        chk("wrap_to_zero", 32'(bus4.hw_counter), 32'd0);

        // Reset during a stalled load clears everything immediately.
        drive_m(1, 1, 4, ALU_LW, 1, 32'h400, 0, 1'b0);
        step();
        idle_m();
        bus.stall = 1'b1;
        bus.dm_r_data = 32'h11111111;
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_we",     32'(bus.rf_we), 32'd0);
        chk("rst_mid_waddr",  32'(bus.rf_waddr), 32'd0);
        chk("rst_mid_wdata",  bus.rf_wdata, 32'd0);
        chk("rst_mid_hw",     bus.hw_counter, 32'd0);
        chk("rst_mid_retire", bus.retire_count, 32'd0);
        bus.stall = 1'b0;
        bus.dm_r_data = 32'h22222222;
        @(posedge clk);
        #1 reset = 1'b0;
        edges = 0;
        step();
        chk("post_rst_we",     32'(bus.rf_we), 32'd0);
        chk("post_rst_retire", bus.retire_count, 32'd0);
        chk("post_rst_hw",     bus.hw_counter, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stage_w.md
Name: stage_w

Overview:
- Writeback stage directly downstream of the memory-access stage.
- Holds the M/W pipeline register. Aligns and sign/zero-extends synchronous data-memory read data for loads. Substitutes the free-running hardware cycle counter for loads from the counter address. Drives the register-file write port and the forwarding bus.
- Also owns the retired-instruction counter.

Parameters:
CNT_W, 32, width of the hardware cycle counter and the retire counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
m_valid  in  1  instruction in M is valid
m_reg_we  in  1  instruction writes rd
m_rd  in  5  destination register
m_alucode  in  6  ALU/load opcode code (ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, others)
m_is_load  in  1  instruction is a load
m_alu_result  in  32  ALU result / effective address
m_byte_offset  in  5  byte offset ×8 from M (0, 8, 16, 24)
m_is_hardware  in  1  address equals HARDWARE_COUNTER_ADDR
dm_r_data  in  32  synchronous RAM read data, valid the cycle after M
stall  in  1  freeze W (external hazard/UART back-pressure)
flush  in  1  kill the incoming M instruction
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
fwd_valid  out  1  forwarding entry valid (same as rf_we)
hw_counter  out  CNT_W  free-running cycle counter
retire_count  out  CNT_W  retired valid instructions

Behaviour:
- Reset (async, immediate): W register cleared (valid=0, reg_we=0, rd=0, alucode=0, result=0, offset=0, is_load=0, is_hw=0). Hold register and hold_valid cleared. hw_counter=0, retire_count=0. Consequently rf_we=0, rf_waddr=0, rf_wdata=0.
- W register update on posedge clk:
  - stall=1: hold all fields.
  - else flush=1: load a bubble (valid=0, reg_we=0; other fields don't-care, drive 0).
  - else: capture all m_* fields.
  - flush during stall has no effect; the bubble is inserted on the first non-stall edge if flush is still high.
- Load data source:
  - raw = w_is_hw ? hw_counter : (hold_valid ? hold_data : dm_r_data).
  - Shifted value: sh = raw >> w_byte_offset.
- Extension:
  - LB: sign-extend sh[7:0].
  - LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0].
  - LHU: zero-extend sh[15:0].
  - LW: raw unshifted.
  - Any other alucode with is_load=1 yields raw.
  - Misaligned LH at offset 24 yields bits [31:24] with the upper half from the shift (zeros) before extension. No trap.
- rf_wdata = w_is_load ? extended : w_alu_result (combinational from the W register).
- rf_we = w_valid & w_reg_we & (w_rd != 0) & ~stall. rf_waddr = w_rd.
- fwd_valid = rf_we.
- Stall hold register (sync RAM output moves when M advances):
  - First stalled cycle with w_valid & w_is_load & ~hold_valid: hold_data <= dm_r_data, hold_valid <= 1.
  - On the first non-stall edge: hold_valid <= 0.
  - The stalled load therefore writes back the data read in its original W cycle.
- hw_counter: +1 every cycle, including during stall/flush. Wraps from 2^CNT_W−1 to 0.
  - A load from the counter returns the counter value during that load's unstalled W (writeback) cycle, i.e. pre-increment.
- retire_count: +1 on each edge where rf_we-qualifying condition w_valid & ~stall holds, independent of reg_we and rd. Wraps.
- Reset mid-stall discards the held instruction and hold data. No writeback occurs.
- Latency:
  - M inputs appear on rf_* one cycle later.
  - Each stall cycle adds one cycle; the write is asserted only on the final, unstalled cycle.

Test Plan:
- Reset released, no valid input for 5 cycles -> rf_we=0, hw_counter=5, retire_count=0.
- ALU op rd=5, alu_result=0x12345678, reg_we=1 -> next cycle rf_we=1, waddr=5, wdata=0x12345678. Repeat with rd=0 -> rf_we=0, retire_count still increments.
- LB offset 8, dm_r_data=0x0080FF00 -> wdata=0xFFFFFFFF. LBU same -> 0x000000FF. LH offset 16 -> 0x00000080. LW -> 0x0080FF00.
- LW with m_is_hardware=1 at hw_counter=100 in W -> wdata=100.
- LW in W with dm_r_data=0xCAFEBABE, stall for 3 cycles while dm_r_data changes to 0 -> rf_we=0 during stall, then rf_we=1 with wdata=0xCAFEBABE. retire_count increments once.
- Flush with a valid M instruction -> next cycle rf_we=0. Assert reset mid-stall -> all outputs 0 immediately. hw_counter preset to 0xFFFFFFFF wraps to 0.
